// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo
//
// Byte FIFO placed directly after the RS232 core's Avalon-ST receive source.
// Received bytes, with their framing/parity error flag, are buffered and
// presented to a bursty consumer through an Avalon-ST source with full
// ready/valid backpressure. The block also reports the fill level, an
// almost-full warning and a saturating count of received error bytes.
//
// Build option:
//   UART_RX_FIFO_ERR_DROP_EN  when defined, error beats are handshaken and
//                             counted but not stored; out_error is tied to 0.
//                             When undefined, error beats are stored and
//                             emerge in order with out_error=1.
//
// Parameters:
//   DEPTH        entries, power of two, 4..256
//   ALMOST_FULL  almost_full threshold, 1..DEPTH
//
// Ports:
//   clk_clk        in   sole clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   in_data        in   [7:0] received byte
//   in_error       in   error flag for in_data
//   in_valid       in   in_data/in_error valid
//   in_ready       out  FIFO can accept (not full)
//   out_data       out  [7:0] head byte
//   out_error      out  head error flag
//   out_valid      out  FIFO non-empty
//   out_ready      in   consumer accepts head
//   clear          in   synchronous flush of pointers, count and err_count
//   fill_level     out  [AW:0] stored entries
//   almost_full    out  fill_level >= ALMOST_FULL
//   err_count      out  [7:0] accepted error beats, saturating at 255

module uart_rx_byte_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [7:0]               in_data,
    input  logic                     in_error,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     almost_full,
    output logic [7:0]               err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(ALMOST_FULL);

`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Error beats never reach storage, so only the data byte is kept.
    localparam int MW = 8;
`else
    localparam int MW = 9;
`endif

    logic [MW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    err_count_reg;

    logic accept;
    logic consume;
    logic store;
    logic full;

    // Status flags come straight from the registered count, so in_ready has
    // no combinational path from out_ready.
    assign full      = (count_reg == FULL_LVL);
    assign in_ready  = !full;
    assign out_valid = (count_reg != '0);

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Error beats complete the handshake but are discarded.
    assign store     = accept && !in_error;
    assign out_data  = mem[rd_ptr_reg];
    assign out_error = 1'b0;
`else
    assign store     = accept;
    assign out_data  = mem[rd_ptr_reg][7:0];
    assign out_error = mem[rd_ptr_reg][8];
`endif

    assign fill_level  = count_reg;
    assign almost_full = (count_reg >= AF_LVL);
    assign err_count   = err_count_reg;

    // Storage is not reset; only the pointers/count define what is valid.
    always_ff @(posedge clk_clk) begin
        if (store && !clear) begin
`ifdef UART_RX_FIFO_ERR_DROP_EN
            mem[wr_ptr_reg] <= in_data;
`else
            mem[wr_ptr_reg] <= {in_error, in_data};
`endif
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_count_reg <= '0;
        end else if (clear) begin
            // Flush wins over any transfer in the same cycle.
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_count_reg <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (store) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (consume) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({store, consume})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Dropped error beats are still counted.
            if (accept && in_error && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
module tb_uart_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_error = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_error;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] fill_level;
    logic       almost_full;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    int         err_model = 0;

    uart_rx_byte_fifo #(.DEPTH(16), .ALMOST_FULL(12)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_data       (in_data),
        .in_error      (in_error),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_error     (out_error),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clear         (clear),
        .fill_level    (fill_level),
        .almost_full   (almost_full),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard: samples at the falling edge, compares status with
    // the queue model, then predicts the transfers of the coming rising edge.
    always @(negedge clk) begin
        chk("mon_fill", 32'(fill_level), 32'(exp_q.size()));
        chk("mon_in_ready", 32'(in_ready), 32'(exp_q.size() != 16));
        chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("mon_almost_full", 32'(almost_full), 32'(exp_q.size() >= 12));
        chk("mon_err_count", 32'(err_count), 32'(err_model));
        if (rst_n) begin
            if (clear) begin
                exp_q.delete();
                err_model = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        chk("mon_out_data", 32'(out_data), 32'(e[7:0]));
                        chk("mon_out_error", 32'(out_error), 32'(e[8]));
                    end
                end
                if (in_valid && in_ready) begin
                    if (in_error && err_model < 255) err_model++;
`ifdef UART_RX_FIFO_ERR_DROP_EN
                    if (!in_error) exp_q.push_back({1'b0, in_data});
`else
                    exp_q.push_back({in_error, in_data});
`endif
                end
            end
        end
        $display("cyc t=%0t fill=%0d in=%0b/%0b out=%0b/%0b data=%0h err=%0d",
                 $time, fill_level, in_valid, in_ready, out_valid, out_ready, out_data, err_count);
    end

    task automatic send(input logic [7:0] d, input logic e);
        logic acc;
        int   n;
        in_data  = d;
        in_error = e;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic pop_head(input string nm, input logic [7:0] d, input logic e);
        chk({nm, "_valid"}, 32'(out_valid), 32'(1));
        chk({nm, "_data"}, 32'(out_data), 32'(d));
        chk({nm, "_error"}, 32'(out_error), 32'(e));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'(0));
        chk("drain_fill", 32'(fill_level), 32'(0));
    endtask

    initial begin
        // Reset and reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_fill", 32'(fill_level), 32'(0));
        chk("rst_almost_full", 32'(almost_full), 32'(0));
        chk("rst_err", 32'(err_count), 32'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three bytes, then drain in order
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        chk("t1_fill", 32'(fill_level), 32'(3));
        pop_head("t1_b0", 8'h41, 1'b0);
        pop_head("t1_b1", 8'h42, 1'b0);
        pop_head("t1_b2", 8'h43, 1'b0);
        chk("t1_empty", 32'(out_valid), 32'(0));
        chk("t1_fill0", 32'(fill_level), 32'(0));

        // Error byte between two good bytes
        send(8'h10, 1'b0);
        send(8'h55, 1'b1);
        send(8'h20, 1'b0);
        chk("t2_err", 32'(err_count), 32'(1));
`ifdef UART_RX_FIFO_ERR_DROP_EN
        chk("t2_fill", 32'(fill_level), 32'(2));
        pop_head("t2_b0", 8'h10, 1'b0);
        pop_head("t2_b1", 8'h20, 1'b0);
`else
        chk("t2_fill", 32'(fill_level), 32'(3));
        pop_head("t2_b0", 8'h10, 1'b0);
        pop_head("t2_b1", 8'h55, 1'b1);
        pop_head("t2_b2", 8'h20, 1'b0);
`endif
        chk("t2_empty", 32'(out_valid), 32'(0));

        // Fill to full, almost_full threshold, held 17th byte
        for (int i = 0; i < 16; i++) begin
            send(8'h80 + 8'(i), 1'b0);
            if (i == 10) chk("t3_af_at11", 32'(almost_full), 32'(0));
            if (i == 11) chk("t3_af_at12", 32'(almost_full), 32'(1));
        end
        chk("t3_full_fill", 32'(fill_level), 32'(16));
        chk("t3_full_in_ready", 32'(in_ready), 32'(0));
        fork
            send(8'hF0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        chk("t3_after17_fill", 32'(fill_level), 32'(16));
        chk("t3_head", 32'(out_data), 32'(8'h81));
        drain();

        // Sustained streaming at fill_level 8 with pointer wrap
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(8'h20 + 8'(i), 1'b0);
        out_ready = 1'b0;
        chk("t4_fill", 32'(fill_level), 32'(8));
        chk("t4_head", 32'(out_data), 32'(8'h40));
        drain();

        // 300 error beats saturate err_count
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(8'(i), 1'b1);
        drain();
        chk("t5_err_sat", 32'(err_count), 32'(255));

        // Clear with concurrent write
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        chk("t5_fill2", 32'(fill_level), 32'(2));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_fill", 32'(fill_level), 32'(0));
        chk("t5_clr_valid", 32'(out_valid), 32'(0));
        chk("t5_clr_err", 32'(err_count), 32'(0));

        // Asynchronous reset mid-stream at fill_level 5
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        err_model = 0;
        #1;
        chk("t6_rst_fill", 32'(fill_level), 32'(0));
        chk("t6_rst_valid", 32'(out_valid), 32'(0));
        chk("t6_rst_in_ready", 32'(in_ready), 32'(1));
        chk("t6_rst_err", 32'(err_count), 32'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h99, 1'b0);
        chk("t6_lat_valid", 32'(out_valid), 32'(1));
        chk("t6_lat_data", 32'(out_data), 32'(8'h99));
        drain();

        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_fifo.md
# uart_rx_byte_fifo

Byte FIFO that sits directly downstream of the RS232 core's Avalon-ST receive source. It absorbs received bytes, with or without their error flag, and presents them to the consuming logic through an Avalon-ST source with full ready/valid backpressure. It decouples the UART's byte rate from a bursty consumer and reports fill level, an almost-full warning and a saturating receive-error count.

## Interface
Parameters:
- DEPTH, 16 — entries; power of two, 4..256; AW = log2(DEPTH)
- ALMOST_FULL, 12 — almost_full asserts when fill_level >= this; must be 1..DEPTH

Ports:
- clk_clk  in  1  sole clock; all logic rising-edge
- reset_reset_n  in  1  asynchronous, active-low reset; deassertion synchronous to clk_clk externally
- in_data  in  8  byte from RS232 receive source
- in_error  in  1  framing/parity error flag for in_data
- in_valid  in  1  in_data/in_error valid
- in_ready  out  1  FIFO can accept; equals !full
- out_data  out  8  head-of-FIFO byte
- out_error  out  1  head entry error flag
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- clear  in  1  synchronous flush
- fill_level  out  AW+1  stored entries, 0..DEPTH
- almost_full  out  1  fill_level >= ALMOST_FULL
- err_count  out  8  accepted bytes with in_error=1, saturates at 255

## Operation
- Storage: DEPTH-entry register array, 9 bits wide (data + error); write pointer, read pointer (AW bits, wrap modulo DEPTH) and count register (AW+1 bits).
- Input beat accepted when in_valid && in_ready. Accepted beat is written to mem[wr_ptr] and wr_ptr increments, except in the drop case under Configuration.
- Output beat consumed when out_valid && out_ready; rd_ptr increments.
- Head presentation: out_data/out_error = mem[rd_ptr], combinational read of registered storage; out_valid = (count != 0).
- count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Full (count == DEPTH): in_ready=0; no write. Empty: out_valid=0; out_data is don't-care, not required to be stable.
- Simultaneous read and write when count is 1..DEPTH-1: both proceed, count unchanged. Writing while full is impossible because in_ready=0. Reading while empty is impossible because out_valid=0.
- err_count increments on every accepted beat with in_error=1, in both configurations. It holds at 255.
- clear=1: on the next edge wr_ptr, rd_ptr, count and err_count go to 0. clear overrides any simultaneous accept or consume, which are discarded. in_ready stays at !full during the clear cycle.
- Reset (asynchronous, any time, including mid-burst): pointers, count and err_count go to 0. Storage contents are not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, fill_level=0, almost_full=0, err_count=0. out_data and out_error are undefined.
- Latency: a byte accepted at edge N gives out_valid=1 with that byte in the cycle after edge N (1 cycle) when the FIFO was empty.
- Throughput: one byte in and one byte out per cycle sustained.
- fill_level, almost_full and in_ready are registered-count derived and update on the edge after the transfer.
- in_ready does not depend combinationally on out_ready: no pass-through when full.

## Configuration
- UART_RX_FIFO_ERR_DROP_EN defined:
  - Accepted beats with in_error=1 are handshaken (in_ready honoured) but not written and do not change count.
  - out_error is tied to 0.
  - err_count still counts them.
- Undefined:
  - Error beats are stored like any other beat and emerge with out_error=1 in order.

## Test plan
- Reset, then write 0x41,0x42,0x43 with out_ready=0 -> fill_level=3, out_valid=1, out_data=0x41. Then out_ready=1 for 3 cycles -> bytes 0x41,0x42,0x43 in order, then out_valid=0, fill_level=0.
- Fill with 16 bytes (DEPTH=16) with out_ready=0 -> in_ready=0 after the 16th; a 17th byte held valid is not lost; almost_full=1 from fill_level=12. One read -> in_ready=1 and the 17th byte is accepted.
- At fill_level=8, in_valid=1 and out_ready=1 held for 40 cycles -> fill_level stays 8, pointers wrap, output order matches input.
- Send 0x55 with in_error=1 between 0x10 and 0x20:
  - Macro undefined -> out sequence 0x10/0, 0x55/1, 0x20/0 and err_count=1.
  - Macro defined -> out sequence 0x10, 0x20 and err_count=1.
- 300 error beats -> err_count=255 (saturated). clear pulse -> err_count=0, fill_level=0, out_valid=0 next cycle, even with a concurrent write.
- Assert reset_reset_n=0 mid-stream, between clock edges, at fill_level=5 -> outputs return to reset values immediately. After release, the first new byte appears on out_data one cycle after acceptance.
